id_exe_control_stage: RTL

- Parametrised, registered successor to the combinational instruction decoder. Decodes mode/OP/S into execute-stage control and holds it in the ID/EXE control pipeline register.
- Handles pipeline stall, flush and condition-fail bubbles.
- Adds multi-cycle multiply sequencing: an FSM holds a MUL/MLA in EXE for MUL_CYCLES cycles and back-pressures upstream.

---
 rtl/id_exe_control_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/id_exe_control_stage.sv
// id_exe_control_stage
//   Registered ID/EXE control stage. Decodes mode/OP/S into execute-stage
//   control and holds it in the ID/EXE pipeline register. It also inserts
//   bubbles for stall, flush and failed conditions. MUL/MLA is held in EXE
//   for MUL_CYCLES cycles, and busy back-pressures the upstream stages.
//
//   Ports
//     clk, rst          rising-edge clock, async active-high reset
//     valid_in          ID holds a real instruction
//     cond_pass         condition-check result for the ID instruction
//     stall_in/flush_in bubble requests (flush has priority)
//     S, mode, OP       instruction fields
//     is_mul/accumulate MUL/MLA flags
//     busy              comb; high while a multi-cycle MUL occupies EXE
//     valid_out..EXE_CMD registered execute-stage control
module id_exe_control_stage #(
  parameter int MUL_CYCLES  = 3,
  parameter int SUPPORT_MUL = 1,
  parameter int CMD_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             cond_pass,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             S,
  input  logic [1:0]       mode,
  input  logic [3:0]       OP,
  input  logic             is_mul,
  input  logic             accumulate,
  output logic             busy,
  output logic             valid_out,
  output logic             S_out,
  output logic             MEM_R,
  output logic             MEM_W,
  output logic             WB_EN,
  output logic             B,
  output logic             MUL_EN,
  output logic             MUL_ACC,
  output logic             mul_last,
  output logic [CMD_W-1:0] EXE_CMD
);

  typedef struct packed {
    logic             valid;
    logic             s;
    logic             mem_r;
    logic             mem_w;
    logic             wb_en;
    logic             b;
    logic             mul_en;
    logic             mul_acc;
    logic             mul_last;
    logic [CMD_W-1:0] cmd;
  } ctrl_t;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  ctrl_t      dec, ctrl_q, ctrl_d;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cmd4;
  logic       accept;

  // Decode of the ID instruction, assuming it is accepted.
  always_comb begin
    dec       = '0;
    cmd4      = 4'b0000;
    dec.valid = 1'b1;
    dec.s     = S;
    case (mode)
      2'b00: begin
        if (is_mul && (SUPPORT_MUL != 0)) begin
          cmd4        = 4'b1010;
          dec.mul_en  = 1'b1;
          dec.mul_acc = accumulate;
        end else begin
          case (OP)
            4'b1101: begin cmd4 = 4'b0001; dec.wb_en = 1'b1; end // MOV
            4'b1111: begin cmd4 = 4'b1001; dec.wb_en = 1'b1; end // MVN
            4'b0100: begin cmd4 = 4'b0010; dec.wb_en = 1'b1; end // ADD
            4'b0101: begin cmd4 = 4'b0011; dec.wb_en = 1'b1; end // ADC
            4'b0010: begin cmd4 = 4'b0100; dec.wb_en = 1'b1; end // SUB
            4'b0110: begin cmd4 = 4'b0101; dec.wb_en = 1'b1; end // SBC
            4'b0000: begin cmd4 = 4'b0110; dec.wb_en = 1'b1; end // AND
            4'b1100: begin cmd4 = 4'b0111; dec.wb_en = 1'b1; end // ORR
            4'b0001: begin cmd4 = 4'b1000; dec.wb_en = 1'b1; end // EOR
            4'b1010: cmd4 = 4'b0100;                             // CMP
            4'b1000: cmd4 = 4'b0110;                             // TST
            default: cmd4 = 4'b0000;
          endcase
        end
      end
      2'b01: begin
        cmd4 = 4'b0010;
        if (S) begin
          dec.mem_r = 1'b1;
          dec.wb_en = 1'b1;
        end else begin
          dec.mem_w = 1'b1;
        end
      end
      2'b10:   dec.b = 1'b1;
      default: ;
    endcase
    dec.cmd = CMD_W'(cmd4);
  end

  assign accept = valid_in & cond_pass & ~stall_in & ~flush_in;

  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!accept) begin
          ctrl_d = '0;
        end else begin
          ctrl_d = dec;
          if (dec.mul_en) begin
            if (MUL_CYCLES > 1) begin
              // Write-back is deferred to the final occupancy cycle.
              ctrl_d.wb_en    = 1'b0;
              ctrl_d.mul_last = 1'b0;
              cnt_d           = 4'(MUL_CYCLES - 1);
              state_d         = MUL_RUN;
            end else begin
              ctrl_d.wb_en    = 1'b1;
              ctrl_d.mul_last = 1'b1;
            end
          end
        end
      end
      MUL_RUN: begin
        // Control is held; ID inputs, stall and flush are ignored here.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ctrl_d.wb_en    = 1'b1;
          ctrl_d.mul_last = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == MUL_RUN);
  assign valid_out = ctrl_q.valid;
  assign S_out     = ctrl_q.s;
  assign MEM_R     = ctrl_q.mem_r;
  assign MEM_W     = ctrl_q.mem_w;
  assign WB_EN     = ctrl_q.wb_en;
  assign B         = ctrl_q.b;
  assign MUL_EN    = ctrl_q.mul_en;
  assign MUL_ACC   = ctrl_q.mul_acc;
  assign mul_last  = ctrl_q.mul_last;
  assign EXE_CMD   = ctrl_q.cmd;

endmodule
